// File: rtl/ddr3_resp_pkg.sv
// Shared definitions for the DDR3 DDIO responder: command encodings,
// error bit positions, burst geometry and the storage index width.
package ddr3_resp_pkg;

  // {cs, ras, cas, we} encodings; every other code decodes as NOP.
  typedef enum logic [3:0] {
    CMD_MRS = 4'b0000,
    CMD_REF = 4'b0001,
    CMD_PRE = 4'b0010,
    CMD_ACT = 4'b0011,
    CMD_WR  = 4'b0100,
    CMD_RD  = 4'b0101,
    CMD_NOP = 4'b0111
  } cmd_e;

  // Bit positions inside the sticky o_err vector.
  localparam int ERR_ACT_OPEN    = 0;
  localparam int ERR_BANK_CLOSED = 1;
  localparam int ERR_REF_OPEN    = 2;
  localparam int ERR_TCCD        = 3;
  localparam int ERR_BITS        = 4;

  // BL8 moves four hi/lo beat pairs, one pair per clock.
  localparam int BL8_BEATS = 4;
  localparam int BEAT_BITS = 2;
  localparam int BANK_BITS = 3;
  localparam int NUM_BANKS = 8;
  localparam int COL_BITS  = 7;  // col[9:3]; col[2:0] is ignored for BL8

  // Storage index = {ba, row, col[9:3], beat}.
  function automatic int idx_width(input int row_bits);
    return BANK_BITS + row_bits + COL_BITS + BEAT_BITS;
  endfunction

  // Command decode; a deselected or clock-disabled device sees NOP.
  function automatic cmd_e decode_cmd(input logic cke, input logic cs,
                                      input logic ras, input logic cas,
                                      input logic we);
    if (!cke) return CMD_NOP;
    case ({cs, ras, cas, we})
      4'b0011: return CMD_ACT;
      4'b0101: return CMD_RD;
      4'b0100: return CMD_WR;
      4'b0010: return CMD_PRE;
      4'b0001: return CMD_REF;
      4'b0000: return CMD_MRS;
      default: return CMD_NOP;
    endcase
  endfunction

endpackage

// File: rtl/ddr3_ddio_responder_if.sv
// Controller <-> responder DDIO bus: command/address, write data and
// masks toward the memory, read data, strobes and status back.
interface ddr3_ddio_responder_if #(
  parameter int DQ_WIDTH   = 16,
  parameter int DQS_GROUPS = 2
);
  logic                  ddr_cke;
  logic                  ddr_cs;
  logic                  ddr_ras;
  logic                  ddr_cas;
  logic                  ddr_we;
  logic [15:0]           ddr_addr;
  logic [2:0]            ddr_ba;
  logic                  ddr_odt;
  logic [DQ_WIDTH-1:0]   i_dq_hi;
  logic [DQ_WIDTH-1:0]   i_dq_lo;
  logic [DQS_GROUPS-1:0] i_dm_hi;
  logic [DQS_GROUPS-1:0] i_dm_lo;
  logic [DQ_WIDTH-1:0]   o_dq_hi;
  logic [DQ_WIDTH-1:0]   o_dq_lo;
  logic [DQS_GROUPS-1:0] o_dqs_hi;
  logic [DQS_GROUPS-1:0] o_dqs_lo;
  logic [DQS_GROUPS-1:0] o_dqs_n_hi;
  logic [DQS_GROUPS-1:0] o_dqs_n_lo;
  logic                  o_rd_valid;
  logic [3:0]            o_err;

  modport master (
    output ddr_cke, ddr_cs, ddr_ras, ddr_cas, ddr_we, ddr_addr, ddr_ba,
           ddr_odt, i_dq_hi, i_dq_lo, i_dm_hi, i_dm_lo,
    input  o_dq_hi, o_dq_lo, o_dqs_hi, o_dqs_lo, o_dqs_n_hi, o_dqs_n_lo,
           o_rd_valid, o_err
  );

  modport slave (
    input  ddr_cke, ddr_cs, ddr_ras, ddr_cas, ddr_we, ddr_addr, ddr_ba,
           ddr_odt, i_dq_hi, i_dq_lo, i_dm_hi, i_dm_lo,
    output o_dq_hi, o_dq_lo, o_dqs_hi, o_dqs_lo, o_dqs_n_hi, o_dqs_n_lo,
           o_rd_valid, o_err
  );
endinterface

// File: rtl/ddr3_resp_bank_table.sv
// Per-bank open flag and latched low row bits. ACT opens and latches,
// PRE / auto-precharge close one bank, PRE with A10 closes all.
module ddr3_resp_bank_table
  import ddr3_resp_pkg::*;
#(
  parameter int ROW_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 act_en,
  input  logic                 close_en,
  input  logic                 close_all,
  input  logic [BANK_BITS-1:0] ba,
  input  logic [ROW_BITS-1:0]  row_in,
  output logic                 sel_open,
  output logic [ROW_BITS-1:0]  sel_row,
  output logic                 any_open
);

  logic [NUM_BANKS-1:0] open_q;
  logic [ROW_BITS-1:0]  row_q [NUM_BANKS];

  // Open/row table update; ACT and close never occur in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      open_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) row_q[b] <= '0;
    end else if (act_en) begin
      open_q[ba] <= 1'b1;
      row_q[ba]  <= row_in;
    end else if (close_en) begin
      if (close_all) open_q     <= '0;
      else           open_q[ba] <= 1'b0;
    end
  end

  assign sel_open = open_q[ba];
  assign sel_row  = row_q[ba];
  assign any_open = |open_q;

endmodule

// File: rtl/ddr3_ddio_responder.sv
// DDR3 device-side responder on the controller's DDIO hi/lo buses:
// command decode, bank tracking, BL8 write capture with byte masks and
// BL8 read return after CL. Optional ODT checking and an error counter
// are built when DDR3_RESP_ODT_CHECK_EN is defined.
module ddr3_ddio_responder
  import ddr3_resp_pkg::*;
#(
  parameter int DQ_WIDTH   = 16,
  parameter int DQS_GROUPS = 2,
  parameter int CL         = 6,
  parameter int CWL        = 5,
  parameter int ROW_BITS   = 2
) (
  input logic                   clk,
  input logic                   reset,
  ddr3_ddio_responder_if.slave  bus
`ifdef DDR3_RESP_ODT_CHECK_EN
  ,
  output logic                  o_odt_err,
  output logic [7:0]            o_err_cnt
`endif
);

  localparam int IDX_W  = idx_width(ROW_BITS);
  localparam int WORD_W = 2 * DQ_WIDTH;
  localparam int DEPTH  = 1 << IDX_W;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] base;
  } pipe_t;

  cmd_e                cmd;
  logic                is_rw, ccd_viol, closed_viol, rw_ok, rd_acc, wr_acc;
  logic                sel_open, any_open;
  logic [ROW_BITS-1:0] sel_row;
  logic [IDX_W-1:0]    cmd_base;
  logic [ERR_BITS-1:0] err_now, err_q;
  logic [1:0]          ccd_hold;

  assign cmd         = decode_cmd(bus.ddr_cke, bus.ddr_cs, bus.ddr_ras,
                                  bus.ddr_cas, bus.ddr_we);
  assign is_rw       = (cmd == CMD_RD) || (cmd == CMD_WR);
  assign ccd_viol    = is_rw && (ccd_hold != 2'd0);
  assign closed_viol = is_rw && !sel_open;
  assign rw_ok       = is_rw && !ccd_viol && !closed_viol;
  assign rd_acc      = rw_ok && (cmd == CMD_RD);
  assign wr_acc      = rw_ok && (cmd == CMD_WR);
  assign cmd_base    = {bus.ddr_ba, sel_row, bus.ddr_addr[9:3], 2'b00};

  always_comb begin
    err_now                  = '0;
    err_now[ERR_ACT_OPEN]    = (cmd == CMD_ACT) && sel_open;
    err_now[ERR_BANK_CLOSED] = closed_viol;
    err_now[ERR_REF_OPEN]    = (cmd == CMD_REF) && any_open;
    err_now[ERR_TCCD]        = ccd_viol;
  end

  // Auto-precharge closes the bank on the command cycle; the burst keeps
  // the row already folded into cmd_base.
  ddr3_resp_bank_table #(.ROW_BITS(ROW_BITS)) u_bank_table (
    .clk       (clk),
    .reset     (reset),
    .act_en    (cmd == CMD_ACT),
    .close_en  ((cmd == CMD_PRE) || (rw_ok && bus.ddr_addr[10])),
    .close_all ((cmd == CMD_PRE) && bus.ddr_addr[10]),
    .ba        (bus.ddr_ba),
    .row_in    (bus.ddr_addr[ROW_BITS-1:0]),
    .sel_open  (sel_open),
    .sel_row   (sel_row),
    .any_open  (any_open)
  );

  // tCCD guard: blocks RD/WR for three cycles after an accepted RD/WR.
  always_ff @(posedge clk) begin
    if (reset)                  ccd_hold <= 2'd0;
    else if (rw_ok)             ccd_hold <= 2'd3;
    else if (ccd_hold != 2'd0)  ccd_hold <= ccd_hold - 2'd1;
  end

  // Sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) err_q <= '0;
    else       err_q <= err_q | err_now;
  end

  pipe_t rd_pipe [CL];
  pipe_t wr_pipe [CWL];

  // Command latency pipelines; stage N holds the command N+1 edges later.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CL; i++)  rd_pipe[i] <= '0;
      for (int i = 0; i < CWL; i++) wr_pipe[i] <= '0;
    end else begin
      rd_pipe[0] <= '{valid: rd_acc, base: cmd_base};
      wr_pipe[0] <= '{valid: wr_acc, base: cmd_base};
      for (int i = 1; i < CL; i++)  rd_pipe[i] <= rd_pipe[i-1];
      for (int i = 1; i < CWL; i++) wr_pipe[i] <= wr_pipe[i-1];
    end
  end

  logic             rd_go, wr_go;
  logic [IDX_W-1:0] rd_idx, wr_idx, rd_next, wr_next;
  logic [1:0]       rd_left, wr_left;

  // Beat selection: beat 0 comes from the pipeline tail, beats 1..3 from
  // the burst counters. Accepted bursts are 4 apart, so they never collide.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    rd_go  = 1'b0;
    rd_idx = rd_next;
    wr_go  = 1'b0;
    wr_idx = wr_next;
    if (rd_pipe[CL-1].valid) begin
      rd_go  = 1'b1;
      rd_idx = rd_pipe[CL-1].base;
    end else if (rd_left != 2'd0) begin
      rd_go = 1'b1;
    end
    if (wr_pipe[CWL-1].valid) begin
      wr_go  = 1'b1;
      wr_idx = wr_pipe[CWL-1].base;
    end else if (wr_left != 2'd0) begin
      wr_go = 1'b1;
    end
    // A reset edge landing mid-burst must not commit the pending beat.
    if (reset) wr_go = 1'b0;
  end

  // Burst counters for beats 1..3.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_left <= 2'd0;
      rd_next <= '0;
      wr_left <= 2'd0;
      wr_next <= '0;
    end else begin
      if (rd_pipe[CL-1].valid) begin
        rd_left <= 2'(BL8_BEATS - 1);
        rd_next <= {rd_pipe[CL-1].base[IDX_W-1:2], 2'd1};
      end else if (rd_left != 2'd0) begin
        rd_left <= rd_left - 2'd1;
        rd_next <= {rd_next[IDX_W-1:2], rd_next[1:0] + 2'd1};
      end
      if (wr_pipe[CWL-1].valid) begin
        wr_left <= 2'(BL8_BEATS - 1);
        wr_next <= {wr_pipe[CWL-1].base[IDX_W-1:2], 2'd1};
      end else if (wr_left != 2'd0) begin
        wr_left <= wr_left - 2'd1;
        wr_next <= {wr_next[IDX_W-1:2], wr_next[1:0] + 2'd1};
      end
    end
  end

  logic [WORD_W-1:0] mem [DEPTH];

  // Byte-enable write of {hi, lo}; a set dm bit keeps that lane's byte.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; contents survive reset, and a
    // resettable array would not map onto RAM.
    if (wr_go) begin
      for (int g = 0; g < DQS_GROUPS; g++) begin
        if (!bus.i_dm_hi[g]) mem[wr_idx][DQ_WIDTH + 8*g +: 8] <= bus.i_dq_hi[8*g +: 8];
        if (!bus.i_dm_lo[g]) mem[wr_idx][8*g +: 8]            <= bus.i_dq_lo[8*g +: 8];
      end
    end
  end

  logic                  rd_valid_q;
  logic [DQ_WIDTH-1:0]   dq_hi_q, dq_lo_q;
  logic [DQS_GROUPS-1:0] dqs_hi_q;

  // Registered read port doubles as the output stage; a same-edge write
  // to the same index is not yet visible, so old data is returned.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      dq_hi_q    <= '0;
      dq_lo_q    <= '0;
      dqs_hi_q   <= '0;
    end else begin
      rd_valid_q         <= rd_go;
      dqs_hi_q           <= {DQS_GROUPS{rd_go}};
      {dq_hi_q, dq_lo_q} <= rd_go ? mem[rd_idx] : '0;
    end
  end

  // The preamble (both strobe halves low at CL-1) equals the idle level,
  // so the strobe needs no dedicated preamble state.
  assign bus.o_rd_valid = rd_valid_q;
  assign bus.o_dq_hi    = dq_hi_q;
  assign bus.o_dq_lo    = dq_lo_q;
  assign bus.o_dqs_hi   = dqs_hi_q;
  assign bus.o_dqs_lo   = '0;
  assign bus.o_dqs_n_hi = ~dqs_hi_q;
  assign bus.o_dqs_n_lo = '1;
  assign bus.o_err      = err_q;

`ifdef DDR3_RESP_ODT_CHECK_EN
  logic odt_now;
  assign odt_now = (rd_valid_q && bus.ddr_odt) || (wr_go && !bus.ddr_odt);

  // ODT misuse flag and saturating count of cycles with any error.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_odt_err <= 1'b0;
      o_err_cnt <= 8'd0;
    end else begin
      if (odt_now) o_odt_err <= 1'b1;
      if (((|err_now) || odt_now) && (o_err_cnt != 8'hFF))
        o_err_cnt <= o_err_cnt + 8'd1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.ddr_addr[15:11], bus.ddr_addr[2:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{bus.ddr_addr[15:11], bus.ddr_addr[2:0], bus.ddr_odt};
`endif

endmodule

// File: tb/tb_ddr3_ddio_responder.sv
// Directed bench for ddr3_ddio_responder: write/read bursts, byte masks,
// bank-state and tCCD errors, streaming reads and reset behaviour.
module tb_ddr3_ddio_responder;

  localparam int DQ_WIDTH   = 16;
  localparam int DQS_GROUPS = 2;
  localparam int CL         = 6;
  localparam int CWL        = 5;
  localparam int ROW_BITS   = 2;

  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_NOP = 4'b0111;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  ddr3_ddio_responder_if #(.DQ_WIDTH(DQ_WIDTH), .DQS_GROUPS(DQS_GROUPS)) bus ();

`ifdef DDR3_RESP_ODT_CHECK_EN
  logic       odt_err;
  logic [7:0] err_cnt;
`endif

  ddr3_ddio_responder #(
    .DQ_WIDTH(DQ_WIDTH), .DQS_GROUPS(DQS_GROUPS), .CL(CL), .CWL(CWL),
    .ROW_BITS(ROW_BITS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus)
`ifdef DDR3_RESP_ODT_CHECK_EN
    ,
    .o_odt_err(odt_err),
    .o_err_cnt(err_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs set before, outputs sampled at the following negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] code, input logic [2:0] ba,
                       input logic [15:0] addr);
    {bus.ddr_cs, bus.ddr_ras, bus.ddr_cas, bus.ddr_we} = code;
    bus.ddr_ba   = ba;
    bus.ddr_addr = addr;
    tick();
    {bus.ddr_cs, bus.ddr_ras, bus.ddr_cas, bus.ddr_we} = C_NOP;
    bus.ddr_addr = 16'h0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Beat k lives in bits [16k +: 16]; dm for beat k in bits [2k +: 2].
  task automatic wr_burst(input logic [2:0] ba, input logic [15:0] addr,
                          input logic [63:0] hi, input logic [63:0] lo,
                          input logic [7:0] dm_hi, input logic [7:0] dm_lo);
    drive(C_WR, ba, addr);
    for (int i = 0; i < CWL - 1; i++) tick();
    for (int k = 0; k < 4; k++) begin
      bus.i_dq_hi = hi[16*k +: 16];
      bus.i_dq_lo = lo[16*k +: 16];
      bus.i_dm_hi = dm_hi[2*k +: 2];
      bus.i_dm_lo = dm_lo[2*k +: 2];
      tick();
    end
    bus.i_dq_hi = '0;
    bus.i_dq_lo = '0;
    bus.i_dm_hi = '0;
    bus.i_dm_lo = '0;
  endtask

  task automatic rd_check(input string tag, input logic [2:0] ba,
                          input logic [15:0] addr, input logic [63:0] hi,
                          input logic [63:0] lo);
    drive(C_RD, ba, addr);
    for (int i = 0; i < CL - 1; i++) tick();
    check({tag, "_pre_valid"}, 64'(bus.o_rd_valid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("%s_valid%0d", tag, k), 64'(bus.o_rd_valid), 64'd1);
      check($sformatf("%s_hi%0d", tag, k), 64'(bus.o_dq_hi), 64'(hi[16*k +: 16]));
      check($sformatf("%s_lo%0d", tag, k), 64'(bus.o_dq_lo), 64'(lo[16*k +: 16]));
      if (k == 0) begin
        check({tag, "_dqs_hi"},   64'(bus.o_dqs_hi),   64'h3);
        check({tag, "_dqs_lo"},   64'(bus.o_dqs_lo),   64'h0);
        check({tag, "_dqs_n_hi"}, 64'(bus.o_dqs_n_hi), 64'h0);
        check({tag, "_dqs_n_lo"}, 64'(bus.o_dqs_n_lo), 64'h3);
      end
    end
    tick();
    check({tag, "_post_valid"}, 64'(bus.o_rd_valid), 64'd0);
    check({tag, "_post_dq"}, 64'(bus.o_dq_hi), 64'd0);
  endtask

  logic [63:0] stream_hi;

  initial begin
    reset        = 1'b1;
    bus.ddr_cke  = 1'b1;
    {bus.ddr_cs, bus.ddr_ras, bus.ddr_cas, bus.ddr_we} = C_NOP;
    bus.ddr_addr = '0;
    bus.ddr_ba   = '0;
    bus.ddr_odt  = 1'b0;
    bus.i_dq_hi  = '0;
    bus.i_dq_lo  = '0;
    bus.i_dm_hi  = '0;
    bus.i_dm_lo  = '0;
    tick();
    tick();
    tick();
    reset = 1'b0;

    // Reset state.
    check("rst_valid",    64'(bus.o_rd_valid), 64'd0);
    check("rst_err",      64'(bus.o_err),      64'd0);
    check("rst_dq",       64'({bus.o_dq_hi, bus.o_dq_lo}), 64'd0);
    check("rst_dqs",      64'({bus.o_dqs_hi, bus.o_dqs_lo}), 64'd0);
    check("rst_dqs_n",    64'({bus.o_dqs_n_hi, bus.o_dqs_n_lo}), 64'hF);

    // Basic write then read, bank 0 row 1 column 0x08.
    drive(C_ACT, 3'd0, 16'h0001);
    wr_burst(3'd0, 16'h0008, 64'h7777_5555_3333_1111, 64'h8888_6666_4444_2222,
             8'h00, 8'h00);
    rd_check("basic", 3'd0, 16'h0008, 64'h7777_5555_3333_1111,
             64'h8888_6666_4444_2222);
    check("basic_err", 64'(bus.o_err), 64'd0);

    // Byte mask: lane 0 of hi masked on beat 0, beats 1..3 fully masked.
    wr_burst(3'd0, 16'h0010, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA,
             8'h00, 8'h00);
    wr_burst(3'd0, 16'h0010, 64'hFFFF_FFFF_FFFF_1111, 64'hFFFF_FFFF_FFFF_2222,
             8'hFD, 8'hFC);
    rd_check("mask", 3'd0, 16'h0010, 64'hAAAA_AAAA_AAAA_11AA,
             64'hAAAA_AAAA_AAAA_2222);

    // RD to a never-activated bank is dropped; ACT on an open bank flags.
    drive(C_RD, 3'd3, 16'h0008);
    check("closed_err", 64'(bus.o_err), 64'h2);
    for (int i = 0; i < CL - 1; i++) tick();
    check("closed_no_valid", 64'(bus.o_rd_valid), 64'd0);
    tick();
    check("closed_no_valid2", 64'(bus.o_rd_valid), 64'd0);
    drive(C_ACT, 3'd0, 16'h0001);
    check("act_open_err", 64'(bus.o_err), 64'h3);

    // Two RDs four cycles apart stream eight contiguous beats.
    stream_hi = 64'h7777_5555_3333_1111;
    drive(C_RD, 3'd0, 16'h0008);
    tick();
    tick();
    tick();
    drive(C_RD, 3'd0, 16'h0010);
    tick();
    check("stream_pre", 64'(bus.o_rd_valid), 64'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("stream_valid%0d", k), 64'(bus.o_rd_valid), 64'd1);
      if (k == 4) stream_hi = 64'hAAAA_AAAA_AAAA_11AA;
      check($sformatf("stream_hi%0d", k), 64'(bus.o_dq_hi),
            64'(stream_hi[16*(k%4) +: 16]));
    end
    tick();
    check("stream_post", 64'(bus.o_rd_valid), 64'd0);
    check("stream_err", 64'(bus.o_err), 64'h3);

    // RDs two cycles apart: the second is dropped with a tCCD error.
    drive(C_RD, 3'd0, 16'h0008);
    tick();
    drive(C_RD, 3'd0, 16'h0010);
    check("tccd_err", 64'(bus.o_err), 64'hB);
    tick();
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("tccd_valid%0d", k), 64'(bus.o_rd_valid), 64'd1);
    end
    check("tccd_last_hi", 64'(bus.o_dq_hi), 64'h7777);
    tick();
    check("tccd_dropped", 64'(bus.o_rd_valid), 64'd0);

    // Reset clears errors; storage keeps its contents.
    do_reset();
    check("rst2_err", 64'(bus.o_err), 64'd0);

    // Auto-precharge read still returns the latched row, then bank closes.
    drive(C_ACT, 3'd0, 16'h0001);
    rd_check("ap", 3'd0, 16'h0408, 64'h7777_5555_3333_1111,
             64'h8888_6666_4444_2222);
    check("ap_err", 64'(bus.o_err), 64'd0);
    drive(C_RD, 3'd0, 16'h0008);
    check("ap_closed_err", 64'(bus.o_err), 64'h2);
    for (int i = 0; i < CL; i++) tick();
    check("ap_closed_no_valid", 64'(bus.o_rd_valid), 64'd0);

    // PRE all before REF is clean; REF with an open bank flags.
    drive(C_ACT, 3'd2, 16'h0000);
    drive(C_PRE, 3'd5, 16'h0400);
    drive(C_REF, 3'd0, 16'h0000);
    check("ref_closed", 64'(bus.o_err), 64'h2);
    drive(C_ACT, 3'd1, 16'h0002);
    drive(C_REF, 3'd0, 16'h0000);
    check("ref_open", 64'(bus.o_err), 64'h6);

    // Reset two cycles after RD aborts the burst.
    do_reset();
    drive(C_ACT, 3'd0, 16'h0001);
    drive(C_RD, 3'd0, 16'h0008);
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("abort_valid%0d", k), 64'(bus.o_rd_valid), 64'd0);
    end
    check("abort_err", 64'(bus.o_err), 64'd0);

    // Data written before both resets is still readable.
    drive(C_ACT, 3'd0, 16'h0001);
    rd_check("persist", 3'd0, 16'h0008, 64'h7777_5555_3333_1111,
             64'h8888_6666_4444_2222);
    check("persist_err", 64'(bus.o_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
